// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared matrix datapath parameters and collector state encoding
package matrix_pkg;

    localparam int DATA_W      = 16;
    localparam int NUM_RESULTS = 9;
    localparam int IDX_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } collector_state_t;

endpackage

// File: rtl/result_buffer.sv
// rtl/result_buffer.sv - NUM_RESULTS x DATA_W register file, sync write, async read
module result_buffer #(
    parameter int DATA_W      = 16,
    parameter int NUM_RESULTS = 9,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [IDX_W-1:0] DEPTH = IDX_W'(NUM_RESULTS);

    logic [DATA_W-1:0] mem_q [NUM_RESULTS];

    // Contents intentionally survive reset; only the collector's control state is cleared.
    always_ff @(posedge clk) begin
        if (we && (waddr < DEPTH)) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (raddr < DEPTH) begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/result_collector.sv
// rtl/result_collector.sv - captures one result frame then drains it to the host
// Optional frame checksum output enabled by RESULT_CHECKSUM_EN.
module result_collector
    import matrix_pkg::*;
#(
    parameter int DATA_W      = matrix_pkg::DATA_W,
    parameter int NUM_RESULTS = matrix_pkg::NUM_RESULTS,
    parameter int IDX_W       = matrix_pkg::IDX_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       din,
    input  logic                    din_valid,
    input  logic                    frame_start,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_W-1:0]       rd_data,
    output logic [IDX_W-1:0]        rd_index,
    output logic                    frame_done,
    output logic                    busy,
`ifdef RESULT_CHECKSUM_EN
    output logic [DATA_W+IDX_W-1:0] frame_sum,
`endif
    output logic                    overrun
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_RESULTS - 1);

    collector_state_t  state_q, state_d;
    logic [IDX_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [IDX_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;

    logic              buf_we;
    logic [IDX_W-1:0]  buf_waddr;
    logic [DATA_W-1:0] buf_rdata;

    result_buffer #(
        .DATA_W      (DATA_W),
        .NUM_RESULTS (NUM_RESULTS),
        .IDX_W       (IDX_W)
    ) u_buffer (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (din),
        .raddr (rd_cnt_q),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        buf_we       = 1'b0;
        buf_waddr    = '0;
        case (state_q)
            ST_IDLE: begin
                if (din_valid && frame_start) begin
                    buf_we = 1'b1;
                    if (LAST == '0) begin
                        state_d      = ST_DRAIN;
                        wr_cnt_d     = '0;
                        rd_cnt_d     = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d  = ST_CAPTURE;
                        wr_cnt_d = IDX_W'(1);
                    end
                end
            end
            ST_CAPTURE: begin
                if (din_valid) begin
                    buf_we = 1'b1;
                    if (frame_start) begin
                        // A new word 0 mid-frame abandons the partial frame.
                        wr_cnt_d  = IDX_W'(1);
                        overrun_d = 1'b1;
                    end else begin
                        buf_waddr = wr_cnt_q;
                        if (wr_cnt_q == LAST) begin
                            state_d      = ST_DRAIN;
                            wr_cnt_d     = '0;
                            rd_cnt_d     = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            wr_cnt_d = wr_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (din_valid) begin
                    overrun_d = 1'b1;
                end
                if (rd_ready) begin
                    if (rd_cnt_q == LAST) begin
                        rd_cnt_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                wr_cnt_d = '0;
                rd_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        rd_valid   = (state_q == ST_DRAIN);
        rd_data    = rd_valid ? buf_rdata : '0;
        rd_index   = rd_valid ? rd_cnt_q : '0;
        busy       = (state_q != ST_IDLE);
        frame_done = frame_done_q;
        overrun    = overrun_q;
    end

`ifdef RESULT_CHECKSUM_EN
    logic [DATA_W+IDX_W-1:0] sum_q, sum_d;

    // Only word-0 writes target address 0, so that is where the sum restarts.
    always_comb begin
        sum_d = sum_q;
        if (buf_we) begin
            if (buf_waddr == '0) begin
                sum_d = (DATA_W+IDX_W)'(din);
            end else begin
                sum_d = sum_q + (DATA_W+IDX_W)'(din);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign frame_sum = sum_q;
`endif

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - directed table-driven bench for result_collector
module tb_result_collector;

    typedef logic [15:0] frame_t [9];

    typedef struct {
        logic        dv;
        logic        fs;
        logic [15:0] din;
        logic        rr;
        logic        e_valid;
        logic [15:0] e_data;
        logic [3:0]  e_index;
        logic        e_fd;
        logic        e_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [3:0]  rd_index;
    logic        frame_done;
    logic        busy;
    logic        overrun;
`ifdef RESULT_CHECKSUM_EN
    logic [19:0] frame_sum;
`endif

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    vec_t  vecs [18];
    frame_t fr_a, fr_b;

    always #5 clk = ~clk;

    result_collector dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_index    (rd_index),
        .frame_done  (frame_done),
        .busy        (busy),
`ifdef RESULT_CHECKSUM_EN
        .frame_sum   (frame_sum),
`endif
        .overrun     (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic dv, input logic fs, input logic [15:0] d, input logic rr);
        din_valid   = dv;
        frame_start = fs;
        din         = d;
        rd_ready    = rr;
        @(posedge clk);
        #1;
        if (frame_done) fd_cnt++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        din_valid = 1'b0;
        frame_start = 1'b0;
        din = '0;
        rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        fd_cnt = 0;
    endtask

    task automatic capture(input frame_t w, input int gap_at, input int gap_len);
        for (int i = 0; i < 9; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    step(1'b0, 1'b0, 16'h0, 1'b0);
                    check("gap_busy", busy, 1);
                    check("gap_rd_valid", rd_valid, 0);
                end
            end
            step(1'b1, (i == 0), w[i], 1'b0);
        end
        din_valid = 1'b0;
        frame_start = 1'b0;
        check("capture_frame_done", frame_done, 1);
        check("capture_rd_valid", rd_valid, 1);
    endtask

    // ready_mode 0: always ready; 1: ready pattern 1,0,0 repeating
    task automatic drain_expect(input frame_t w, input int ready_mode, input logic collide);
        int n = 0;
        int k = 0;
        logic rr;
        for (int cyc = 0; cyc < 60 && n < 9; cyc++) begin
            check("drain_rd_valid", rd_valid, 1);
            check("drain_rd_data", rd_data, w[n]);
            check("drain_rd_index", rd_index, n);
            rr = (ready_mode == 0) ? 1'b1 : ((k % 3) == 0);
            k++;
            if (collide && cyc == 0) step(1'b1, 1'b1, 16'hFFFF, rr);
            else                     step(1'b0, 1'b0, 16'h0, rr);
            if (rr) n++;
        end
        check("drain_complete", n, 9);
        check("drain_end_rd_valid", rd_valid, 0);
        check("drain_end_busy", busy, 0);
        check("frame_done_pulses", fd_cnt, 1);
        rd_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 9; i++) begin
            fr_a[i] = 16'(i + 1);
            fr_b[i] = 16'hAA + 16'(i);
        end
        for (int i = 0; i < 18; i++) begin
            vecs[i].rr = 1'b1;
            if (i < 9) begin
                vecs[i].dv = 1'b1;
                vecs[i].fs = (i == 0);
                vecs[i].din = 16'(i + 1);
                vecs[i].e_valid = (i == 8);
                vecs[i].e_data = (i == 8) ? 16'h0001 : 16'h0000;
                vecs[i].e_index = 4'd0;
                vecs[i].e_fd = (i == 8);
                vecs[i].e_busy = 1'b1;
            end else if (i < 17) begin
                vecs[i].dv = 1'b0;
                vecs[i].fs = 1'b0;
                vecs[i].din = 16'h0;
                vecs[i].e_valid = 1'b1;
                vecs[i].e_data = 16'(i - 7);
                vecs[i].e_index = 4'(i - 8);
                vecs[i].e_fd = 1'b0;
                vecs[i].e_busy = 1'b1;
            end else begin
                vecs[i].dv = 1'b0;
                vecs[i].fs = 1'b0;
                vecs[i].din = 16'h0;
                vecs[i].e_valid = 1'b0;
                vecs[i].e_data = 16'h0;
                vecs[i].e_index = 4'd0;
                vecs[i].e_fd = 1'b0;
                vecs[i].e_busy = 1'b0;
            end
        end

        do_reset();
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_rd_index", rd_index, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
`ifdef RESULT_CHECKSUM_EN
        check("reset_frame_sum", frame_sum, 0);
`endif

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].dv, vecs[i].fs, vecs[i].din, vecs[i].rr);
            check("vec_rd_valid", rd_valid, vecs[i].e_valid);
            check("vec_rd_data", rd_data, vecs[i].e_data);
            check("vec_rd_index", rd_index, vecs[i].e_index);
            check("vec_frame_done", frame_done, vecs[i].e_fd);
            check("vec_busy", busy, vecs[i].e_busy);
            check("vec_overrun", overrun, 0);
`ifdef RESULT_CHECKSUM_EN
            if (i >= 8) check("vec_frame_sum", frame_sum, 20'h0002D);
`endif
        end

        fd_cnt = 0;
        capture(fr_a, -1, 0);
        drain_expect(fr_a, 1, 1'b0);
        check("backpressure_overrun", overrun, 0);

        fd_cnt = 0;
        capture(fr_a, 5, 3);
        drain_expect(fr_a, 0, 1'b0);

        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, (i == 0), 16'h10 + 16'(i), 1'b0);
        check("pre_restart_overrun", overrun, 0);
        capture(fr_b, -1, 0);
        check("restart_overrun", overrun, 1);
        drain_expect(fr_b, 0, 1'b0);

        do_reset();
        step(1'b1, 1'b0, 16'h0055, 1'b0);
        check("stray_idle_overrun", overrun, 0);
        check("stray_idle_busy", busy, 0);
        fd_cnt = 0;
        capture(fr_a, -1, 0);
        drain_expect(fr_a, 0, 1'b1);
        check("collision_overrun", overrun, 1);

        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, (i == 0), fr_b[i], 1'b0);
        din_valid = 1'b0;
        frame_start = 1'b0;
        check("mid_capture_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_rd_valid", rd_valid, 0);
        check("async_frame_done", frame_done, 0);
        check("async_overrun", overrun, 0);
        check("async_rd_index", rd_index, 0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", busy, 0);
        fd_cnt = 0;
        capture(fr_a, -1, 0);
        drain_expect(fr_a, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Receiving end of the matrix-multiply result stream: captures the serialized result words the controller/datapath emits (one word per cycle, sequenced by the final mux), buffers a full frame, then drains it to a host port with a valid/ready handshake.
- Sits between the final output mux of the matrix datapath and the host/testbench readout.

Parameters:
- DATA_W, 16, width of one result word.
- NUM_RESULTS, 9, result words per frame (3x3 product matrix).
- IDX_W, 4, width of the word index; must satisfy 2**IDX_W >= NUM_RESULTS.

Ports:
- clk  in  1  single clock; all state updates on the rising edge (the controller updates on the falling edge, giving half a cycle of settle time).
- reset  in  1  asynchronous, active-low; clears all state.
- din  in  DATA_W  result word from the final mux.
- din_valid  in  1  din holds a valid result this cycle.
- frame_start  in  1  qualified by din_valid; marks word 0 of a frame.
- rd_valid  out  1  rd_data/rd_index valid to host.
- rd_ready  in  1  host accepts the current word.
- rd_data  out  DATA_W  buffered result word.
- rd_index  out  IDX_W  index (0..NUM_RESULTS-1) of rd_data.
- frame_done  out  1  one-cycle pulse when the last word of a frame is captured.
- busy  out  1  high in CAPTURE or DRAIN.
- overrun  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values:
  - state=IDLE, wr_cnt=0, rd_cnt=0.
  - rd_valid=0, rd_data=0, rd_index=0, frame_done=0, busy=0, overrun=0.
  - Buffer contents are not cleared.
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - din_valid && frame_start: write buf[0]=din, wr_cnt=1, go to CAPTURE.
  - din_valid without frame_start: word ignored, no flag.
  - If NUM_RESULTS==1: go directly to DRAIN and pulse frame_done.
- CAPTURE:
  - din_valid && !frame_start: write buf[wr_cnt], wr_cnt++.
  - If wr_cnt was NUM_RESULTS-1: go to DRAIN, rd_cnt=0, frame_done=1 for exactly the cycle after the last write edge.
  - din_valid && frame_start: restart the frame (buf[0]=din, wr_cnt=1) and set overrun.
  - din_valid low: hold. No timeout.
- DRAIN:
  - rd_valid=1, rd_data=buf[rd_cnt], rd_index=rd_cnt. rd_data is taken combinationally from the buffer, so it is valid the same cycle DRAIN is entered.
  - rd_valid && rd_ready: rd_cnt++. On the last index, go to IDLE; rd_valid drops the next cycle.
  - rd_data/rd_index stay stable while rd_ready is low.
  - Any din_valid in DRAIN: word dropped, overrun set. A frame_start in DRAIN is not accepted.
- Counters never exceed NUM_RESULTS-1; wr_cnt and rd_cnt wrap to 0 on frame completion.
- busy = (state != IDLE).
- Reset asserted mid-CAPTURE or mid-DRAIN: immediate return to IDLE; the partial frame is discarded (frame_done not pulsed).
- Latency:
  - Last input word edge to frame_done: 1 cycle.
  - Same edge to first rd_valid: 1 cycle.
  - Minimum frame turnaround: NUM_RESULTS capture cycles + NUM_RESULTS drain cycles (rd_ready held high).

Optional Feature:
- Macro RESULT_CHECKSUM_EN.
- Defined:
  - Adds output port frame_sum [DATA_W+IDX_W-1:0]: unsigned sum of all words captured in the frame.
  - Accumulator zeroed on the word-0 write (including a restart); updated on every accepted write.
  - frame_sum is stable from the frame_done cycle until the next word-0 write; reset value 0.
- Not defined: port and accumulator absent; all other behaviour identical.

Decomposition:
- Shared package matrix_pkg:
  - DATA_W and NUM_RESULTS defaults.
  - Collector state encoding (IDLE=2'd0, CAPTURE=2'd1, DRAIN=2'd2).
  - Encoding 2'd3 is illegal; the FSM recovers to IDLE.
- Sub-module result_buffer: NUM_RESULTS x DATA_W register file with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- FSM, counters and flags stay in result_collector.

Test Plan:
- Basic frame: reset, then frame_start+din_valid with din=0x0001, then 8 more consecutive words 0x0002..0x0009, rd_ready=1.
  - frame_done pulses once, 1 cycle after word 9.
  - rd_data sequence is 0x0001..0x0009 with rd_index 0..8 over 9 consecutive cycles; busy drops afterwards.
  - With RESULT_CHECKSUM_EN, frame_sum=0x002D.
- Back-pressure: same frame with rd_ready toggling 1,0,0,1,...
  - No word is skipped or duplicated; rd_data/rd_index are held while rd_ready=0.
- Gapped input: din_valid low for 3 cycles between words 4 and 5.
  - Capture stalls; all 9 words are still drained in order and frame_done fires once.
- Restart: frame_start asserted again with din=0x00AA at word 5 of a frame.
  - overrun=1; a new frame begins with rd_data[0]=0x00AA after 8 further words.
- Drain collision: din_valid=1 while in DRAIN.
  - overrun=1; drained data is unchanged.
  - A stray din_valid without frame_start in IDLE leaves overrun=0 (checked on a fresh reset).
- Async reset: reset pulled low mid-CAPTURE (word 3) for less than one clock period.
  - All outputs return to reset values immediately; the next full frame drains correctly.
